// File: rtl/adder_seq_pkg.sv
// Shared types and sizing helpers for the sliced sequential adder.
package adder_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int calcNslice(input int width, input int slice);
    return width / slice;
  endfunction

  // A single-slice configuration still needs a 1-bit index register.
  function automatic int calcIdxWidth(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/adder_seq_ctrl_add_slice.sv
// Combinational SLICE-bit ripple-carry adder built from 1-bit full adders.
module add_slice
  import adder_seq_pkg::*;
#(
  parameter int SLICE = 20
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);

  logic [SLICE:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign s[i]     = x[i] ^ y[i] ^ w_c[i];
    assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
  end

  assign co = w_c[SLICE];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide adder that reuses one SLICE-bit adder over NSLICE cycles, carrying
// between slices in a register, with valid/ready handshakes on both sides.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 100,
  parameter int SLICE = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = calcNslice(WIDTH, SLICE);
  localparam int IW     = calcIdxWidth(NSLICE);

  if ((WIDTH % SLICE) != 0) begin : g_bad_width
    $error("adder_seq_ctrl: WIDTH must be a multiple of SLICE");
  end

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [IW-1:0]    r_idx;

  logic [SLICE-1:0] w_sliceA;
  logic [SLICE-1:0] w_sliceB;
  logic [SLICE-1:0] w_sliceSum;
  logic             w_sliceCo;
  logic             w_accept;
  logic             w_lastSlice;

  assign w_sliceA    = r_a[r_idx*SLICE +: SLICE];
  assign w_sliceB    = r_b[r_idx*SLICE +: SLICE];
  assign w_accept    = start_valid && start_ready;
  assign w_lastSlice = (r_idx == IW'(NSLICE - 1));

  add_slice #(.SLICE(SLICE)) u_slice (
    .x  (w_sliceA),
    .y  (w_sliceB),
    .ci (r_carry),
    .s  (w_sliceSum),
    .co (w_sliceCo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_nextState = RUN;
      RUN:     if (w_lastSlice) w_nextState = DONE;
      DONE:    if (res_ready)   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Index stops at the last slice, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
          end
        end
        RUN: begin
          r_sum[r_idx*SLICE +: SLICE] <= w_sliceSum;
          r_carry                     <= w_sliceCo;
          if (w_lastSlice) r_cout <= w_sliceCo;
          else             r_idx  <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign start_ready = rst_n && (r_state == IDLE);
  assign res_valid   = (r_state == DONE);
  assign busy        = (r_state != IDLE);
  assign sum         = r_sum;
  assign cout        = r_cout;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed self-checking bench for adder_seq_ctrl (WIDTH=100, SLICE=20).
module tb_adder_seq_ctrl;

  localparam int WIDTH = 100;

  logic             clk;
  logic             rst_n;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int total = 0;
  int bad   = 0;

  adder_seq_ctrl #(.WIDTH(WIDTH), .SLICE(20)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic cv);
    a           = av;
    b           = bv;
    cin         = cv;
    start_valid = 1'b1;
  endtask

  // Present operands at a falling edge, let the next rising edge accept them,
  // then drop valid and poison the operand bus.
  task automatic doAccept(input string tag, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic cv);
    applyStimulus(av, bv, cv);
    checkOutput({tag, "_sready"}, 128'(start_ready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    a           = 'x;
    b           = 'x;
    cin         = 1'bx;
  endtask

  task automatic waitResult(input string tag, input logic [WIDTH-1:0] expSum,
                            input logic expCout, input bit chkCarry);
    int cnt = 0;
    while (!res_valid && cnt < 20) begin
      checkOutput({tag, "_busy"}, 128'(busy), 128'(1));
      checkOutput({tag, "_srdyRun"}, 128'(start_ready), 128'(0));
      if (chkCarry) checkOutput({tag, "_carry"}, 128'(dut.r_carry), 128'(1));
      @(negedge clk);
      cnt++;
    end
    if (chkCarry) checkOutput({tag, "_carryLast"}, 128'(dut.r_carry), 128'(1));
    checkOutput({tag, "_latency"}, 128'(cnt), 128'(5));
    checkOutput({tag, "_sum"}, 128'(sum), 128'(expSum));
    checkOutput({tag, "_cout"}, 128'(cout), 128'(expCout));
    checkOutput({tag, "_busyDone"}, 128'(busy), 128'(1));
  endtask

  task automatic releaseResult(input string tag, input logic [WIDTH-1:0] expSum);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput({tag, "_rvalidOff"}, 128'(res_valid), 128'(0));
    checkOutput({tag, "_busyOff"}, 128'(busy), 128'(0));
    checkOutput({tag, "_sreadyIdle"}, 128'(start_ready), 128'(1));
    checkOutput({tag, "_sumHeld"}, 128'(sum), 128'(expSum));
  endtask

  initial begin
    logic [WIDTH-1:0] opA[3];
    logic [WIDTH-1:0] opB[3];
    logic             opC[3];
    logic [WIDTH-1:0] expS[3];
    logic             expC[3];
    int               acc[3];
    int               k;
    int               r;
    int               cyc;
    bit               acceptNow;

    rst_n       = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    a           = '0;
    b           = '0;
    cin         = 1'b0;

    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_sready", 128'(start_ready), 128'(0));
    checkOutput("rst_rvalid", 128'(res_valid), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_sum", 128'(sum), 128'(0));
    checkOutput("rst_cout", 128'(cout), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_sready", 128'(start_ready), 128'(1));

    $display("[TB] basic 1+2");
    doAccept("basic", 100'd1, 100'd2, 1'b0);
    waitResult("basic", 100'd3, 1'b0, 1'b0);
    releaseResult("basic", 100'd3);

    $display("[TB] all ones plus carry in");
    doAccept("ones", {WIDTH{1'b1}}, 100'd0, 1'b1);
    waitResult("ones", 100'd0, 1'b1, 1'b1);
    releaseResult("ones", 100'd0);

    $display("[TB] msb overflow");
    doAccept("msb", 100'd1 << 99, 100'd1 << 99, 1'b0);
    waitResult("msb", 100'd0, 1'b1, 1'b0);
    releaseResult("msb", 100'd0);

    $display("[TB] slice boundary carry");
    doAccept("bound", 100'hFFFFF, 100'd1, 1'b0);
    waitResult("bound", 100'h100000, 1'b0, 1'b0);
    releaseResult("bound", 100'h100000);

    $display("[TB] result held under back-pressure");
    doAccept("hold", 100'd10, 100'd20, 1'b0);
    waitResult("hold", 100'd30, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      start_valid = (i % 2) == 0;
      a           = 100'd1;
      b           = 100'd1;
      cin         = 1'b0;
      @(negedge clk);
      checkOutput("hold_rvalid", 128'(res_valid), 128'(1));
      checkOutput("hold_sum", 128'(sum), 128'(30));
      checkOutput("hold_cout", 128'(cout), 128'(0));
      checkOutput("hold_sready", 128'(start_ready), 128'(0));
    end
    start_valid = 1'b0;
    releaseResult("hold", 100'd30);

    $display("[TB] reset during run");
    doAccept("abort", 100'd3, 100'd4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_idx", 128'(dut.r_idx), 128'(2));
    checkOutput("abort_partial", 128'(sum), 128'(7));
    rst_n = 1'b0;
    #1;
    checkOutput("abort_sum", 128'(sum), 128'(0));
    checkOutput("abort_cout", 128'(cout), 128'(0));
    checkOutput("abort_rvalid", 128'(res_valid), 128'(0));
    checkOutput("abort_busy", 128'(busy), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_sreadyAfter", 128'(start_ready), 128'(1));
    doAccept("after", 100'd5, 100'd7, 1'b0);
    waitResult("after", 100'd12, 1'b0, 1'b0);
    releaseResult("after", 100'd12);

    $display("[TB] back-to-back throughput");
    opA[0] = 100'd100;          opB[0] = 100'd200;     opC[0] = 1'b0;
    expS[0] = 100'd300;         expC[0] = 1'b0;
    opA[1] = {WIDTH{1'b1}};     opB[1] = 100'd1;       opC[1] = 1'b0;
    expS[1] = 100'd0;           expC[1] = 1'b1;
    opA[2] = 100'h12345;        opB[2] = 100'h54321;   opC[2] = 1'b1;
    expS[2] = 100'h66667;       expC[2] = 1'b0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    k   = 0;
    r   = 0;
    cyc = 0;
    res_ready = 1'b1;
    applyStimulus(opA[0], opB[0], opC[0]);
    for (int n = 0; n < 40 && r < 3; n++) begin
      checkOutput("tput_noOverlap", 128'(start_ready & res_valid), 128'(0));
      acceptNow = start_valid && start_ready && (k < 3);
      if (res_valid) begin
        checkOutput("tput_sum", 128'(sum), 128'(expS[r]));
        checkOutput("tput_cout", 128'(cout), 128'(expC[r]));
        r++;
      end
      @(posedge clk);
      cyc++;
      if (acceptNow) begin
        acc[k] = cyc;
        k++;
      end
      @(negedge clk);
      if (acceptNow) begin
        if (k < 3) applyStimulus(opA[k], opB[k], opC[k]);
        else       start_valid = 1'b0;
      end
    end
    start_valid = 1'b0;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("tput_results", 128'(r), 128'(3));
    checkOutput("tput_gap1", 128'(acc[1] - acc[0]), 128'(7));
    checkOutput("tput_gap2", 128'(acc[2] - acc[1]), 128'(7));
    checkOutput("tput_idle", 128'(busy), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
